// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle writes are FIFO-buffered.
// Optional macro WB_BYPASS_EN lets a multi-cycle write skip an empty FIFO when the port is idle.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_waddr,
  input  logic [31:0]              pipe_wdata,
  output logic                     pipe_ready,
  input  logic                     mc_valid,
  input  logic [4:0]               mc_waddr,
  input  logic [31:0]              mc_wdata,
  output logic                     mc_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               chk_reg1,
  input  logic [4:0]               chk_reg2,
  input  logic [4:0]               chk_reg3,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     pend3,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] kill_reg;
  logic [DEPTH-1:0] kill_next;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic [DEPTH-1:0] match3;

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [7:0]       wait_reg;
  logic [7:0]       wait_next;

  logic             fifo_empty;
  logic             fifo_full;
  logic             force_drain;
  logic             head_issue;
  logic             pipe_issue;
  logic             bypass;
  logic             push;
  logic [4:0]       head_addr;
  logic [31:0]      head_data;
  logic             head_kill;

  assign wr_idx     = wr_ptr_reg[AW-1:0];
  assign rd_idx     = rd_ptr_reg[AW-1:0];
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;

  assign head_addr  = addr_mem[rd_idx];
  assign head_data  = data_mem[rd_idx];
  assign head_kill  = kill_reg[rd_idx];

  // A starved head outranks the pipeline; the pipeline must then hold its request.
  assign force_drain = !fifo_empty && (wait_reg >= 8'(MAX_WAIT));
  assign head_issue  = force_drain || (!pipe_we && !fifo_empty);
  assign pipe_issue  = pipe_we && !force_drain;
  assign pipe_ready  = !force_drain;
  assign mc_ready    = !fifo_full;

`ifdef WB_BYPASS_EN
  assign bypass = fifo_empty && !pipe_we && mc_valid;
`else
  assign bypass = 1'b0;
`endif

  // r0 writes are swallowed here so they never occupy a slot.
  assign push = mc_valid && !fifo_full && (mc_waddr != 5'd0) && !bypass;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic is_wr;
      logic is_rd;
      assign is_wr = push && (wr_idx == AW'(gi));
      assign is_rd = head_issue && (rd_idx == AW'(gi));

      // A push lands in a free slot, so it never collides with a kill of a live entry.
      assign valid_next[gi] = is_wr ? 1'b1 : (is_rd ? 1'b0 : valid_reg[gi]);
      assign kill_next[gi]  = is_wr ? 1'b0 :
                              is_rd ? 1'b0 :
                              (kill_reg[gi] ||
                               (pipe_issue && valid_reg[gi] && (addr_mem[gi] == pipe_waddr)));

      assign live[gi]   = valid_reg[gi] && !kill_reg[gi];
      assign match1[gi] = (addr_mem[gi] == chk_reg1);
      assign match2[gi] = (addr_mem[gi] == chk_reg2);
      assign match3[gi] = (addr_mem[gi] == chk_reg3);
    end
  endgenerate

  assign pend1 = (chk_reg1 != 5'd0) && |(live & match1);
  assign pend2 = (chk_reg2 != 5'd0) && |(live & match2);
  assign pend3 = (chk_reg3 != 5'd0) && |(live & match3);

  always_comb begin
    wait_next = wait_reg;
    if (fifo_empty || head_issue)
      wait_next = 8'd0;
    else if (wait_reg != 8'hFF)
      wait_next = wait_reg + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= mc_waddr;
      data_mem[wr_idx] <= mc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= '0;
      kill_reg   <= '0;
      wait_reg   <= 8'd0;
    end else begin
      valid_reg <= valid_next;
      kill_reg  <= kill_next;
      wait_reg  <= wait_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (head_issue)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Write port: killed heads and r0 targets still take the slot but suppress the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (head_issue) begin
      rf_we    <= !head_kill && (head_addr != 5'd0);
      rf_waddr <= head_addr;
      rf_wdata <= head_data;
    end else if (pipe_issue) begin
      rf_we    <= (pipe_waddr != 5'd0);
      rf_waddr <= pipe_waddr;
      rf_wdata <= pipe_wdata;
    end else if (bypass) begin
      rf_we    <= (mc_waddr != 5'd0);
      rf_waddr <= mc_waddr;
      rf_wdata <= mc_wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, priority, drain, starvation, kill, full, r0 and bypass.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_ready;
  logic        mc_valid;
  logic [4:0]  mc_waddr;
  logic [31:0] mc_wdata;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic [4:0]  chk_reg3;
  logic        pend1;
  logic        pend2;
  logic        pend3;
  logic [2:0]  fifo_count;

  logic [31:0] rf_model [32];

  int checks;
  int failures;

  regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .pipe_ready (pipe_ready),
    .mc_valid   (mc_valid),
    .mc_waddr   (mc_waddr),
    .mc_wdata   (mc_wdata),
    .mc_ready   (mc_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .chk_reg1   (chk_reg1),
    .chk_reg2   (chk_reg2),
    .chk_reg3   (chk_reg3),
    .pend1      (pend1),
    .pend2      (pend2),
    .pend3      (pend3),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the register file the arbiter feeds.
  always @(posedge clk)
    if (rf_we) rf_model[rf_waddr] <= rf_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
    chk_reg1 = '0; chk_reg2 = '0; chk_reg3 = '0;

    repeat (2) tick();
    $display("txn reset");
    check_eq("reset_rf_we", rf_we, 0);
    check_eq("reset_rf_waddr", rf_waddr, 0);
    check_eq("reset_rf_wdata", rf_wdata, 0);
    check_eq("reset_mc_ready", mc_ready, 1);
    check_eq("reset_pipe_ready", pipe_ready, 1);
    check_eq("reset_count", fifo_count, 0);
    check_eq("reset_pend1", pend1, 0);
    rst_n = 1'b1;
    tick();

    $display("txn pipe write r9=6");
    pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'd6;
    settle();
    check_eq("pipe_ready", pipe_ready, 1);
    tick();
    pipe_we = 1'b0;
    check_eq("pipe_rf_we", rf_we, 1);
    check_eq("pipe_rf_waddr", rf_waddr, 9);
    check_eq("pipe_rf_wdata", rf_wdata, 6);
    tick();
    check_eq("idle_rf_we", rf_we, 0);
    check_eq("idle_hold_addr", rf_waddr, 9);

    $display("txn mc r20=15 behind pipe r10 x3");
    pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'd100;
    mc_valid = 1'b1; mc_waddr = 5'd20; mc_wdata = 32'd15;
    chk_reg1 = 5'd20;
    tick();
    mc_valid = 1'b0;
    check_eq("drain_count1", fifo_count, 1);
    check_eq("drain_pend_set", pend1, 1);
    tick();
    tick();
    pipe_we = 1'b0;
    check_eq("drain_pipe_addr", rf_waddr, 10);
    check_eq("drain_pend_held", pend1, 1);
    tick();
    check_eq("drain_rf_we", rf_we, 1);
    check_eq("drain_rf_waddr", rf_waddr, 20);
    check_eq("drain_rf_wdata", rf_wdata, 15);
    check_eq("drain_pend_clr", pend1, 0);
    check_eq("drain_count0", fifo_count, 0);
    chk_reg1 = '0;

    $display("txn starvation mc r22=33 under continuous pipe r11");
    pipe_we = 1'b1; pipe_waddr = 5'd11; pipe_wdata = 32'd7;
    mc_valid = 1'b1; mc_waddr = 5'd22; mc_wdata = 32'd33;
    tick();
    mc_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      check_eq($sformatf("starve_ready_c%0d", k), pipe_ready, 1);
      tick();
    end
    settle();
    check_eq("starve_forced", pipe_ready, 0);
    tick();
    check_eq("starve_rf_we", rf_we, 1);
    check_eq("starve_rf_waddr", rf_waddr, 22);
    check_eq("starve_rf_wdata", rf_wdata, 33);
    check_eq("starve_count", fifo_count, 0);
    check_eq("starve_release", pipe_ready, 1);
    tick();
    check_eq("starve_pipe_resume", rf_waddr, 11);
    pipe_we = 1'b0;
    tick();

    $display("txn kill mc r19=2 by pipe r19=40");
    pipe_we = 1'b1; pipe_waddr = 5'd12; pipe_wdata = 32'd1;
    mc_valid = 1'b1; mc_waddr = 5'd19; mc_wdata = 32'd2;
    chk_reg2 = 5'd19;
    tick();
    mc_valid = 1'b0;
    pipe_waddr = 5'd19; pipe_wdata = 32'd40;
    settle();
    check_eq("kill_pend_before", pend2, 1);
    tick();
    pipe_we = 1'b0;
    check_eq("kill_pend_after", pend2, 0);
    check_eq("kill_count1", fifo_count, 1);
    tick();
    check_eq("kill_pop_rf_we", rf_we, 0);
    check_eq("kill_count0", fifo_count, 0);
    tick();
    check_eq("kill_rf_holds_40", rf_model[19], 40);
    chk_reg2 = '0;

    $display("txn fill fifo behind pipe r13, then reset");
    pipe_we = 1'b1; pipe_waddr = 5'd13; pipe_wdata = 32'd5;
    mc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mc_waddr = 5'(24 + i); mc_wdata = 32'(i + 1);
      settle();
      check_eq($sformatf("full_ready_%0d", i), mc_ready, 1);
      tick();
    end
    mc_waddr = 5'd28; mc_wdata = 32'd99;
    check_eq("full_count4", fifo_count, 4);
    check_eq("full_mc_ready", mc_ready, 0);
    tick();
    check_eq("full_no_5th", fifo_count, 4);
    rst_n = 1'b0;
    settle();
    check_eq("midrst_count", fifo_count, 0);
    check_eq("midrst_rf_we", rf_we, 0);
    check_eq("midrst_mc_ready", mc_ready, 1);
    pipe_we = 1'b0; mc_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("txn r0 writes from both sources");
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'd9;
    mc_valid = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'd8;
    tick();
    pipe_we = 1'b0; mc_valid = 1'b0;
    check_eq("r0_rf_we", rf_we, 0);
    check_eq("r0_count", fifo_count, 0);
    tick();

    $display("txn idle mc r21=40");
    mc_valid = 1'b1; mc_waddr = 5'd21; mc_wdata = 32'd40;
    settle();
    check_eq("byp_mc_ready", mc_ready, 1);
    tick();
    mc_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check_eq("byp_rf_we", rf_we, 1);
    check_eq("byp_rf_waddr", rf_waddr, 21);
    check_eq("byp_rf_wdata", rf_wdata, 40);
    check_eq("byp_count", fifo_count, 0);
`else
    check_eq("nobyp_rf_we0", rf_we, 0);
    check_eq("nobyp_count", fifo_count, 1);
    tick();
    check_eq("nobyp_rf_we", rf_we, 1);
    check_eq("nobyp_rf_waddr", rf_waddr, 21);
    check_eq("nobyp_rf_wdata", rf_wdata, 40);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
